// File: rtl/accum_seq_ctrl.sv
// rtl/accum_seq_ctrl.sv - burst sequencer driving a 3-stage pipelined accumulator
module accum_seq_ctrl #(
    parameter int LEN_W  = 8,
    parameter int SIZEIN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              acc_ce1,
    output logic              acc_ce2,
    output logic              acc_ce3,
    output logic              acc_clear_and_go,
    output logic              acc_clear,
    input  logic [SIZEIN:0]   acc_out,
    output logic              res_valid,
    output logic [SIZEIN:0]   res_data,
    input  logic              res_ready,
    output logic              busy,
    output logic              err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_remaining;
    logic             r_first_pend;
    logic             r_v1, r_first1, r_last1;
    logic             r_v2, r_first2, r_last2;
    logic             r_err;

    logic w_run;
    logic w_accept;
    logic w_last_accept;
    logic w_ce3;

    assign w_run         = (r_state == S_RUN);
    assign w_accept      = w_run & in_valid & ~abort & ~rst;
    assign w_last_accept = w_accept & (r_remaining == LEN_W'(1));
    assign w_ce3         = r_v2 & ~abort & ~rst;

    // Reset and abort gate every output combinationally so nothing leaks in that cycle.
    assign in_ready         = w_run & ~abort & ~rst;
    assign acc_ce1          = w_accept;
    assign acc_ce2          = r_v1 & ~abort & ~rst;
    assign acc_ce3          = w_ce3;
    assign acc_clear_and_go = w_ce3 & r_first2;
    assign acc_clear        = rst | abort;
    assign res_valid        = (r_state == S_HOLD) & ~abort & ~rst;
    assign res_data         = rst ? '0 : acc_out;
    assign busy             = (r_state != S_IDLE) & ~rst;
    assign err              = r_err & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_first_pend <= 1'b0;
            r_v1         <= 1'b0;
            r_first1     <= 1'b0;
            r_last1      <= 1'b0;
            r_v2         <= 1'b0;
            r_first2     <= 1'b0;
            r_last2      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) & start & ~abort & (len == '0);
            if (abort) begin
                r_state      <= S_IDLE;
                r_remaining  <= '0;
                r_first_pend <= 1'b0;
                r_v1         <= 1'b0;
                r_first1     <= 1'b0;
                r_last1      <= 1'b0;
                r_v2         <= 1'b0;
                r_first2     <= 1'b0;
                r_last2      <= 1'b0;
            end else begin
                // Tags ride alongside the valid bit so bubbles never disturb them.
                r_v1     <= w_accept;
                r_first1 <= w_accept & r_first_pend;
                r_last1  <= w_last_accept;
                r_v2     <= r_v1;
                r_first2 <= r_first1;
                r_last2  <= r_last1;
                case (r_state)
                    S_IDLE: begin
                        if (start && (len != '0)) begin
                            r_state      <= S_RUN;
                            r_remaining  <= len;
                            r_first_pend <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (w_accept) begin
                            r_remaining  <= r_remaining - LEN_W'(1);
                            r_first_pend <= 1'b0;
                            if (w_last_accept) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (r_v2 && r_last2) begin
                            r_state <= S_HOLD;
                        end
                    end
                    default: begin
                        if (res_ready) begin
                            r_state <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// tb/tb_accum_seq_ctrl.sv - directed and randomized bench for accum_seq_ctrl
module tb_accum_seq_ctrl;

    localparam int LEN_W  = 8;
    localparam int SIZEIN = 16;
    localparam int M_IDLE = 10, M_RUN = 11, M_DRAIN = 12, M_HOLD = 13;

    logic clk = 1'b0;
    logic rst, start, abort, in_valid, res_ready;
    logic [LEN_W-1:0]  len;
    logic [SIZEIN-1:0] in_a, in_b;
    logic in_ready, acc_ce1, acc_ce2, acc_ce3, acc_clear_and_go, acc_clear;
    logic res_valid, busy, err;
    logic [SIZEIN:0] acc_out, res_data;

    always #5 clk = ~clk;

    accum_seq_ctrl #(.LEN_W(LEN_W), .SIZEIN(SIZEIN)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready),
        .acc_ce1(acc_ce1), .acc_ce2(acc_ce2), .acc_ce3(acc_ce3),
        .acc_clear_and_go(acc_clear_and_go), .acc_clear(acc_clear),
        .acc_out(acc_out), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .busy(busy), .err(err)
    );

    // Pipelined accumulator the controller is meant to drive.
    logic [SIZEIN-1:0] e_a, e_b;
    logic [SIZEIN:0]   e_s, e_acc;
    always @(posedge clk) begin
        if (acc_clear) begin
            e_a <= '0; e_b <= '0; e_s <= '0; e_acc <= '0;
        end else begin
            if (acc_ce1) begin e_a <= in_a; e_b <= in_b; end
            if (acc_ce2) e_s <= {e_a[SIZEIN-1], e_a} + {e_b[SIZEIN-1], e_b};
            if (acc_ce3) e_acc <= acc_clear_and_go ? e_s : e_acc + e_s;
        end
    end
    assign acc_out = e_acc;

    // Hand-computed results of the directed bursts, in order.
    logic [SIZEIN:0] lit_res [7] = '{17'd36, 17'd8, 17'd100, 17'd6, 17'd20, 17'h1FFFE, 17'd50};
    int              lit_len [7] = '{4, 3, 2, 1, 4, 1, 2};

    int total = 0, bad = 0;
    int tb_timeouts = 0, seen_to = 0;
    int phase = 0;
    int cyc = 0, k = 0;
    bit fin_done = 0, m_live = 0;

    int m_mode = M_IDLE, m_rem = 0, m_hold_at = 0;
    logic [SIZEIN:0] m_sum = '0;
    bit m_first = 0, m_err = 0, m_err_n;
    bit s2 [int];
    bit s3 [int];
    int n_ce1 = 0, n_ce2 = 0, n_ce3 = 0, n_cag = 0;
    bit e_rdy, e_acc1, e_ce2, e_ce3, e_cag, e_rv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) m_live = 1;
        if (tb_timeouts != seen_to) begin
            chk("wait_bound", 32'(tb_timeouts), 32'(seen_to));
            seen_to = tb_timeouts;
        end
        if (phase == 2 && !fin_done) begin
            chk("lit_count", 32'(k), 32'd7);
            fin_done = 1;
        end
        if (m_live && rst) begin
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_ce1", 32'(acc_ce1), 32'd0);
            chk("rst_ce2", 32'(acc_ce2), 32'd0);
            chk("rst_ce3", 32'(acc_ce3), 32'd0);
            chk("rst_cag", 32'(acc_clear_and_go), 32'd0);
            chk("rst_clear", 32'(acc_clear), 32'd1);
            chk("rst_res_valid", 32'(res_valid), 32'd0);
            chk("rst_res_data", 32'(res_data), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            m_mode = M_IDLE; m_err = 0;
            s2.delete(); s3.delete();
        end else if (m_live) begin
            e_rdy  = (m_mode == M_RUN) && !abort;
            e_acc1 = e_rdy && in_valid;
            e_ce2  = !abort && s2.exists(cyc);
            e_ce3  = !abort && s3.exists(cyc);
            e_cag  = e_ce3 && s3[cyc];
            e_rv   = (m_mode == M_HOLD) && !abort;
            chk("in_ready", 32'(in_ready), 32'(e_rdy));
            chk("ce1", 32'(acc_ce1), 32'(e_acc1));
            chk("ce2", 32'(acc_ce2), 32'(e_ce2));
            chk("ce3", 32'(acc_ce3), 32'(e_ce3));
            chk("clear_and_go", 32'(acc_clear_and_go), 32'(e_cag));
            chk("acc_clear", 32'(acc_clear), 32'(abort));
            chk("res_valid", 32'(res_valid), 32'(e_rv));
            chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
            chk("err", 32'(err), 32'(m_err));
            if (e_rv) chk("res_data", 32'(res_data), 32'(m_sum));
            n_ce1 += int'(acc_ce1); n_ce2 += int'(acc_ce2);
            n_ce3 += int'(acc_ce3); n_cag += int'(acc_clear_and_go);
            if (e_rv && res_ready && phase == 0) begin
                if (k < 7) begin
                    chk("lit_res", 32'(res_data), 32'(lit_res[k]));
                    chk("lit_ce1", 32'(n_ce1), 32'(lit_len[k]));
                    chk("lit_ce2", 32'(n_ce2), 32'(lit_len[k]));
                    chk("lit_ce3", 32'(n_ce3), 32'(lit_len[k]));
                    chk("lit_cag", 32'(n_cag), 32'd1);
                end
                k++;
            end
            m_err_n = (m_mode == M_IDLE) && start && !abort && (len == 0);
            if (abort) begin
                m_mode = M_IDLE;
                s2.delete(); s3.delete();
            end else begin
                case (m_mode)
                    M_IDLE: if (start && len != 0) begin
                        m_mode = M_RUN; m_rem = int'(len); m_sum = '0; m_first = 1;
                        n_ce1 = 0; n_ce2 = 0; n_ce3 = 0; n_cag = 0;
                    end
                    M_RUN: if (e_acc1) begin
                        s2[cyc+1] = 1'b1;
                        s3[cyc+2] = m_first;
                        m_first = 0;
                        m_sum = m_sum + {in_a[SIZEIN-1], in_a} + {in_b[SIZEIN-1], in_b};
                        if (m_rem == 1) begin m_mode = M_DRAIN; m_hold_at = cyc + 3; end
                        m_rem--;
                    end
                    M_DRAIN: if (cyc + 1 == m_hold_at) m_mode = M_HOLD;
                    default: if (res_ready) m_mode = M_IDLE;
                endcase
            end
            m_err = m_err_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l);
        start = 1'b1; len = LEN_W'(l);
        tick();
        start = 1'b0; len = '0;
    endtask

    task automatic send_pair(input int a, input int b);
        int n = 0;
        bit ok;
        in_valid = 1'b1; in_a = SIZEIN'(a); in_b = SIZEIN'(b);
        while (1) begin
            #1;
            ok = in_ready;
            tick();
            if (ok) break;
            n++;
            if (n > 50) begin tb_timeouts++; break; end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int dly);
        int n = 0;
        res_ready = 1'b0;
        while (1) begin
            #1;
            if (res_valid) break;
            tick();
            n++;
            if (n > 50) begin tb_timeouts++; return; end
        end
        repeat (dly) tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        len = '0; in_a = '0; in_b = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Back-to-back burst of four.
        do_start(4);
        send_pair(1, 2); send_pair(3, 4); send_pair(5, 6); send_pair(7, 8);
        wait_result(0);

        // Gapped burst of three.
        do_start(3);
        send_pair(10, -3);  tick();
        send_pair(100, 1);  tick();
        send_pair(-50, -50);
        wait_result(0);

        // Two bursts with a slow consumer on the first.
        do_start(2);
        send_pair(10, 20); send_pair(30, 40);
        wait_result(5);
        do_start(1);
        send_pair(7, -1);
        wait_result(2);

        // Rejected start, abort-with-start in IDLE, start during RUN.
        do_start(0);
        tick(); tick();
        abort = 1'b1; start = 1'b1; len = LEN_W'(3);
        tick();
        abort = 1'b0; start = 1'b0; len = '0;
        tick();
        do_start(4);
        send_pair(1, 1);
        start = 1'b1; len = LEN_W'(2);
        send_pair(2, 2);
        start = 1'b0; len = '0;
        send_pair(3, 3); send_pair(4, 4);
        wait_result(1);

        // Abort half way through, then a fresh single-pair burst.
        do_start(4);
        send_pair(9, 9); send_pair(9, 9);
        abort = 1'b1; tick(); abort = 1'b0;
        tick();
        do_start(1);
        send_pair(-5, 3);
        wait_result(0);

        // Reset while draining, then a clean burst.
        do_start(2);
        send_pair(50, 50); send_pair(60, 60);
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        do_start(2);
        send_pair(11, 12); send_pair(13, 14);
        wait_result(0);

        tick();
        phase = 1;
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom % 400) == 0;
            start     = ($urandom % 5) == 0;
            len       = LEN_W'($urandom_range(0, 5));
            abort     = ($urandom % 60) == 0;
            in_valid  = ($urandom % 3) != 0;
            in_a      = SIZEIN'($urandom);
            in_b      = SIZEIN'($urandom);
            res_ready = ($urandom % 3) == 0;
            tick();
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
        repeat (10) tick();
        phase = 2;
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accum_seq_ctrl.md
ACCUM_SEQ_CTRL -- requirements
Module: accum_seq_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of burst-length field.
REQ-002 SHALL have parameter SIZEIN, default 16: accumulator operand width; the result is SIZEIN+1 bits.
REQ-003 SHALL have port clk  input  1: clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1: begin burst; sampled only in IDLE.
REQ-006 SHALL have port len  input  LEN_W: operand pairs in the burst, sampled with start.
REQ-007 SHALL have port abort  input  1: cancel the current burst.
REQ-008 SHALL have port in_valid  input  1: operand pair on the accumulator a/b inputs is valid.
REQ-009 SHALL have port in_ready  output  1: controller accepts an operand pair.
REQ-010 SHALL have port acc_ce1, acc_ce2, acc_ce3  output  1 each: accumulator stage enables.
REQ-011 SHALL have port acc_clear_and_go  output  1: load, not add, at stage 3.
REQ-012 SHALL have port acc_clear  output  1: synchronous clear of all accumulator registers.
REQ-013 SHALL have port acc_out  input  SIZEIN+1: accumulator result.
REQ-014 SHALL have port res_valid  output  1 / res_data  output  SIZEIN+1 / res_ready  input  1: result handshake.
REQ-015 SHALL have port busy  output  1: state not IDLE.
REQ-016 SHALL have port err  output  1: one-cycle pulse on rejected start.

Function
REQ-017 SHALL implement FSM IDLE, RUN, DRAIN, HOLD.
REQ-018 IDLE: start with len!=0 -> latch len into remaining counter, go RUN; start with len==0 -> stay IDLE, pulse err next cycle.
REQ-019 RUN: in_ready=1; accept = in_valid & in_ready; accept drives acc_ce1=1 in the same cycle; remaining decrements per accept.
REQ-020 Accept with remaining==1 is tagged last; the FSM goes to DRAIN next cycle; in_ready=0 outside RUN.
REQ-021 Each accept SHALL set stage-1 valid; acc_ce2 = stage-1 valid one cycle after accept; acc_ce3 = stage-2 valid two cycles after accept; without accepts (bubbles), ce2/ce3 stay 0 so accumulator state holds.
REQ-022 first/last tags SHALL travel with their pair; acc_clear_and_go = acc_ce3 & first.
REQ-023 Cycle after acc_ce3 with last -> HOLD; res_valid=1; res_data = acc_out (combinational pass-through, stable since no ce is asserted).
REQ-024 Latency: last accepted in cycle T -> ce2 at T+1, ce3 at T+2, res_valid from T+3.
REQ-025 HOLD: res_valid held until res_ready; res_valid & res_ready -> IDLE next cycle; start is ignored in any state other than IDLE (no err).
REQ-026 len==1: single pair carries first and last; result equals a+b.
REQ-027 Sum arithmetic, wrap and overflow belong to the accumulator; the controller never alters data.
REQ-028 abort in any non-IDLE state -> acc_clear=1 for one cycle, all stage valids/tags cleared, no ce asserted that cycle, IDLE next cycle, no res_valid.
REQ-029 abort and start together in IDLE: abort wins; start ignored, no err.
REQ-030 abort in IDLE: acc_clear pulse only, no state change.
REQ-031 busy = (state != IDLE).

Reset
REQ-032 rst SHALL force IDLE, counter 0, stage valids/tags 0, all outputs 0, overriding every other input that cycle.
REQ-033 acc_clear SHALL be 1 during rst cycles so the accumulator is cleared alongside.
REQ-034 rst mid-burst SHALL drop the burst silently; first post-reset start behaves as from power-up.

Verification
REQ-035 start, len=4, pairs (1,2),(3,4),(5,6),(7,8) back-to-back -> clear_and_go with the 1st ce3 only, res_valid at T+3, res_data=36.
REQ-036 len=3, in_valid gapped 1-0-1-0-1 -> ce1/ce2/ce3 each exactly 3 pulses, shifted 0/1/2 cycles; res_data = sum.
REQ-037 Two bursts len=2 then len=1 with res_ready delayed 5 cycles -> res_valid held stable 5 cycles; 2nd result excludes 1st sum (clear_and_go).
REQ-038 start with len=0 -> err one pulse, busy stays 0; start in RUN -> ignored.
REQ-039 abort after 2 of 4 pairs -> acc_clear one cycle, IDLE, no res_valid; following len=1 burst (-5,3) -> res_data=-2.
REQ-040 rst asserted in DRAIN -> all outputs 0, acc_clear=1 during rst; next burst correct.
